// File: rtl/latch_bank_ctrl.sv
// Write sequencer for a bank of transparent D latches on a shared data bus.
// Two requesters are arbitrated round-robin; each write runs SETUP -> OPEN -> HOLD.
module latch_bank_ctrl #(
  parameter int DW        = 8,
  parameter int NLATCH    = 6,
  parameter int AW        = 3,
  parameter int SETUP_CYC = 1,
  parameter int OPEN_CYC  = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [AW-1:0]     addr0,
  input  logic [DW-1:0]     wdata0,
  input  logic              req1,
  input  logic [AW-1:0]     addr1,
  input  logic [DW-1:0]     wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic              err,
  output logic [NLATCH-1:0] lat_en,
  output logic [DW-1:0]     lat_d,
  output logic              busy
);

  localparam int CMAX = (SETUP_CYC > OPEN_CYC) ?
                        ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                        ((OPEN_CYC  > HOLD_CYC) ? OPEN_CYC  : HOLD_CYC);
  localparam int CW = (CMAX < 2) ? 1 : $clog2(CMAX);
  localparam logic [CW-1:0] C_SETUP = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] C_OPEN  = CW'(OPEN_CYC - 1);
  localparam logic [CW-1:0] C_HOLD  = CW'(HOLD_CYC - 1);
  localparam logic [AW:0]   NL      = (AW+1)'(NLATCH);

  typedef enum logic [1:0] {IDLE, SETUP, OPEN, HOLD} state_t;

  state_t              state, state_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic                last_gnt, last_n;
  logic [AW-1:0]       cap_addr, addr_n;
  logic                cap_who, who_n;
  logic                cap_oor, oor_n;
  logic                pick;
  logic                gnt0_n, gnt1_n, done0_n, done1_n, err_n;
  logic [NLATCH-1:0]   en_n, dec;
  logic [DW-1:0]       d_n;

  // Out-of-range addresses match no slot, so the decode is naturally all-zero.
  for (genvar i = 0; i < NLATCH; i++) begin : g_dec
    assign dec[i] = (cap_addr == AW'(i));
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    last_n  = last_gnt;
    addr_n  = cap_addr;
    who_n   = cap_who;
    oor_n   = cap_oor;
    pick    = 1'b0;
    gnt0_n  = 1'b0;
    gnt1_n  = 1'b0;
    done0_n = 1'b0;
    done1_n = 1'b0;
    err_n   = 1'b0;
    en_n    = '0;
    d_n     = lat_d;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          // On a tie the requester that did not win last time goes first.
          pick    = req1 && (!req0 || !last_gnt);
          state_n = SETUP;
          cnt_n   = C_SETUP;
          last_n  = pick;
          who_n   = pick;
          addr_n  = pick ? addr1 : addr0;
          oor_n   = ({1'b0, (pick ? addr1 : addr0)} >= NL);
          d_n     = pick ? wdata1 : wdata0;
          gnt0_n  = !pick;
          gnt1_n  = pick;
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_n = OPEN;
          cnt_n   = C_OPEN;
          en_n    = dec;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      OPEN: begin
        if (cnt == '0) begin
          state_n = HOLD;
          cnt_n   = C_HOLD;
        end else begin
          cnt_n = cnt - CW'(1);
          en_n  = lat_en;
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_n = IDLE;
          done0_n = !cap_who;
          done1_n = cap_who;
          err_n   = cap_oor;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      last_gnt <= 1'b1;
      cap_addr <= '0;
      cap_who  <= 1'b0;
      cap_oor  <= 1'b0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      err      <= 1'b0;
      lat_en   <= '0;
      lat_d    <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      last_gnt <= last_n;
      cap_addr <= addr_n;
      cap_who  <= who_n;
      cap_oor  <= oor_n;
      gnt0     <= gnt0_n;
      gnt1     <= gnt1_n;
      done0    <= done0_n;
      done1    <= done1_n;
      err      <= err_n;
      lat_en   <= en_n;
      lat_d    <= d_n;
      busy     <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_latch_bank_ctrl.sv
// Bench for latch_bank_ctrl: directed scenarios plus random traffic on two instances
// (default timing and a stretched 2/3/2 timing), checked against a cycle-offset model.
module tb_latch_bank_ctrl;
  localparam int DW = 8;
  localparam int NL = 6;
  localparam int AW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_n;
  logic [1:0]             req0, req1;
  logic [1:0][AW-1:0]     addr0, addr1;
  logic [1:0][DW-1:0]     wdata0, wdata1;
  logic [1:0]             gnt0, gnt1, done0, done1, err, busy;
  logic [1:0][NL-1:0]     lat_en;
  logic [1:0][DW-1:0]     lat_d;

  latch_bank_ctrl u_a (
    .clk(clk), .rst_n(rst_n),
    .req0(req0[0]), .addr0(addr0[0]), .wdata0(wdata0[0]),
    .req1(req1[0]), .addr1(addr1[0]), .wdata1(wdata1[0]),
    .gnt0(gnt0[0]), .gnt1(gnt1[0]), .done0(done0[0]), .done1(done1[0]),
    .err(err[0]), .lat_en(lat_en[0]), .lat_d(lat_d[0]), .busy(busy[0]));

  latch_bank_ctrl #(.SETUP_CYC(2), .OPEN_CYC(3), .HOLD_CYC(2)) u_b (
    .clk(clk), .rst_n(rst_n),
    .req0(req0[1]), .addr0(addr0[1]), .wdata0(wdata0[1]),
    .req1(req1[1]), .addr1(addr1[1]), .wdata1(wdata1[1]),
    .gnt0(gnt0[1]), .gnt1(gnt1[1]), .done0(done0[1]), .done1(done1[1]),
    .err(err[1]), .lat_en(lat_en[1]), .lat_d(lat_d[1]), .busy(busy[1]));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: a transaction is described by its grant cycle; every output is a
  // function of the cycle offset from that grant.
  int s_c[2] = '{1, 2};
  int o_c[2] = '{2, 3};
  int h_c[2] = '{1, 2};
  bit          act[2];
  int          off[2];
  bit          who[2];
  bit          last[2];
  logic [AW-1:0] maddr[2];
  logic [DW-1:0] mdata[2];
  logic [DW-1:0] mem[2][NL];
  logic [DW-1:0] q[2][NL];

  function automatic int tlen(int k);
    return s_c[k] + o_c[k] + h_c[k];
  endfunction

  function automatic bit m_gnt(int k, int r);
    return act[k] && off[k] == 0 && int'(who[k]) == r;
  endfunction

  task automatic step_model(int k);
    bit w;
    if (!rst_n) begin
      act[k] = 0; off[k] = 0; last[k] = 1; mdata[k] = '0;
    end else if (!act[k] || off[k] == tlen(k)) begin
      if (req0[k] || req1[k]) begin
        if (req0[k] && req1[k]) w = !last[k];
        else w = req1[k];
        last[k]  = w;
        who[k]   = w;
        act[k]   = 1;
        off[k]   = 0;
        maddr[k] = w ? addr1[k] : addr0[k];
        mdata[k] = w ? wdata1[k] : wdata0[k];
      end else begin
        act[k] = 0;
      end
    end else begin
      off[k]++;
    end
  endtask

  task automatic check_dut(int k);
    logic [NL-1:0] e_en;
    bit fin, in_open;
    fin     = act[k] && off[k] == tlen(k);
    in_open = act[k] && off[k] >= s_c[k] && off[k] < s_c[k] + o_c[k];
    e_en = '0;
    if (in_open && int'(maddr[k]) < NL) begin
      e_en[maddr[k]] = 1'b1;
      mem[k][maddr[k]] = mdata[k];
    end
    chk($sformatf("busy%0d", k),  busy[k],  act[k] && off[k] < tlen(k));
    chk($sformatf("gnt0_%0d", k), gnt0[k],  m_gnt(k, 0));
    chk($sformatf("gnt1_%0d", k), gnt1[k],  m_gnt(k, 1));
    chk($sformatf("done0_%0d", k), done0[k], fin && !who[k]);
    chk($sformatf("done1_%0d", k), done1[k], fin && who[k]);
    chk($sformatf("err%0d", k),   err[k],   fin && int'(maddr[k]) >= NL);
    chk($sformatf("lat_en%0d", k), lat_en[k], e_en);
    chk($sformatf("lat_d%0d", k), lat_d[k], mdata[k]);
    chk($sformatf("onehot%0d", k), $countones(lat_en[k]) <= 1, 1);
    for (int i = 0; i < NL; i++) if (lat_en[k][i]) q[k][i] = lat_d[k];
  endtask

  task automatic cyc();
    for (int k = 0; k < 2; k++) step_model(k);
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) check_dut(k);
  endtask

  task automatic auto_drop(int k);
    if (m_gnt(k, 0)) req0[k] = 1'b0;
    if (m_gnt(k, 1)) req1[k] = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  int g0c, g1c, en_first, en_cnt, done_c, en_or;
  int order[$];

  initial begin
    rst_n = 1'b0;
    req0 = '0; req1 = '0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    for (int k = 0; k < 2; k++) for (int i = 0; i < NL; i++) begin
      mem[k][i] = '0; q[k][i] = '0;
    end
    do_reset();
    chk("rst_busy", busy, 2'b00);
    chk("rst_lat_d", lat_d[0], 8'h00);

    // single write
    req0[0] = 1; addr0[0] = 3'd2; wdata0[0] = 8'hA5;
    for (int c = 1; c <= 6; c++) begin
      cyc();
      auto_drop(0);
      if (c == 1) chk("wr_gnt0", gnt0[0], 1);
      if (c == 1) chk("wr_lat_d", lat_d[0], 8'hA5);
      if (c == 2 || c == 3) chk("wr_en", lat_en[0], 6'b000100);
      if (c == 4) chk("wr_en_off", lat_en[0], 0);
      if (c == 5) chk("wr_done0", done0[0], 1);
      if (c == 5) chk("wr_busy", busy[0], 0);
    end
    chk("wr_latch_q", q[0][2], 8'hA5);

    // tie from reset
    do_reset();
    req0[0] = 1; addr0[0] = 3'd1; wdata0[0] = 8'h11;
    req1[0] = 1; addr1[0] = 3'd3; wdata1[0] = 8'h22;
    g0c = 0; g1c = 0; done_c = 0;
    for (int c = 1; c <= 12; c++) begin
      cyc();
      if (gnt0[0]) g0c = c;
      if (gnt1[0]) begin g1c = c; chk("tie_d1", lat_d[0], 8'h22); end
      if (done0[0]) done_c = c;
      auto_drop(0);
    end
    chk("tie_g0", g0c, 1);
    chk("tie_done0", done_c, 5);
    chk("tie_g1", g1c, 6);

    // fairness
    do_reset();
    req0[0] = 1; addr0[0] = 3'd0; wdata0[0] = 8'h5A;
    req1[0] = 1; addr1[0] = 3'd5; wdata1[0] = 8'hC3;
    order.delete();
    for (int c = 0; c < 80 && order.size() < 4; c++) begin
      cyc();
      if (gnt0[0]) order.push_back(0);
      if (gnt1[0]) order.push_back(1);
      auto_drop(0);
      if (done0[0]) req0[0] = 1;
      if (done1[0]) req1[0] = 1;
    end
    chk("fair_cnt", order.size(), 4);
    for (int i = 0; i < order.size(); i++) chk($sformatf("fair_ord%0d", i), order[i], i % 2);
    req0[0] = 0; req1[0] = 0;
    for (int c = 0; c < 8; c++) cyc();

    // out-of-range address
    req1[0] = 1; addr1[0] = 3'd7; wdata1[0] = 8'h77;
    en_or = 0; done_c = 0;
    for (int c = 1; c <= 6; c++) begin
      cyc();
      auto_drop(0);
      en_or |= int'(lat_en[0]);
      if (done1[0] && err[0]) done_c = c;
    end
    chk("oor_en", en_or, 0);
    chk("oor_done_err", done_c, 5);

    // reset during the first OPEN cycle
    req0[0] = 1; addr0[0] = 3'd4; wdata0[0] = 8'h3C;
    cyc(); auto_drop(0);
    cyc();
    chk("mid_en_open", lat_en[0], 6'b010000);
    rst_n = 0;
    cyc();
    rst_n = 1;
    chk("mid_en", lat_en[0], 0);
    chk("mid_d", lat_d[0], 0);
    chk("mid_busy", busy[0], 0);
    chk("mid_done", {done0[0], done1[0], err[0]}, 0);
    req0[0] = 1; addr0[0] = 3'd1; wdata0[0] = 8'h01;
    req1[0] = 1; addr1[0] = 3'd2; wdata1[0] = 8'h02;
    cyc();
    chk("mid_tie_g0", gnt0[0], 1);
    auto_drop(0);
    for (int c = 0; c < 12; c++) begin cyc(); auto_drop(0); end

    // stretched timing on the second instance
    req0[1] = 1; addr0[1] = 3'd5; wdata0[1] = 8'h96;
    en_first = 0; en_cnt = 0; done_c = 0;
    for (int c = 1; c <= 10; c++) begin
      cyc();
      if (c == 1) chk("tm_gnt", gnt0[1], 1);
      auto_drop(1);
      if (lat_en[1] != 0) begin
        en_cnt++;
        if (en_first == 0) en_first = c;
      end
      if (done0[1]) done_c = c;
    end
    chk("tm_en_first", en_first, 3);
    chk("tm_en_cnt", en_cnt, 3);
    chk("tm_done", done_c, 8);

    // random traffic on both instances
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (m_gnt(k, 0)) req0[k] = 0;
        else if (!req0[k] && $urandom_range(3) == 0) begin
          req0[k] = 1; addr0[k] = AW'($urandom_range(7)); wdata0[k] = DW'($urandom);
        end
        if (m_gnt(k, 1)) req1[k] = 0;
        else if (!req1[k] && $urandom_range(3) == 0) begin
          req1[k] = 1; addr1[k] = AW'($urandom_range(7)); wdata1[k] = DW'($urandom);
        end
      end
      rst_n = ($urandom_range(199) != 0);
      cyc();
    end
    rst_n = 1; req0 = '0; req1 = '0;
    for (int c = 0; c < 12; c++) cyc();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NL; i++) chk($sformatf("latch%0d_%0d", k, i), q[k][i], mem[k][i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/latch_bank_ctrl.md
Name: latch_bank_ctrl

Overview:
- Controller and arbiter for a bank of NLATCH transparent D latches that share one data bus. Each latch has a level-sensitive enable: q follows d while en=1 and holds otherwise.
- Accepts write requests from two requesters and arbitrates between them round-robin.
- Sequences each write as setup, then enable-open, then hold, driving the shared data bus and one-hot latch enables.
- Sits between the requesters and the latch bank, and is the only driver of the latch d/en pins.

Parameters:
- DW, 8, data width of the shared latch data bus.
- NLATCH, 6, number of latches in the bank.
- AW, 3, address width; must satisfy 2^AW >= NLATCH.
- SETUP_CYC, 1, cycles lat_d is stable before the enable opens (>=1).
- OPEN_CYC, 2, cycles the selected enable is high (>=1).
- HOLD_CYC, 1, cycles lat_d is held after the enable closes (>=1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- req0  input  1  requester 0 write request (level).
- addr0  input  AW  requester 0 target latch index.
- wdata0  input  DW  requester 0 write data.
- req1  input  1  requester 1 write request (level).
- addr1  input  AW  requester 1 target latch index.
- wdata1  input  DW  requester 1 write data.
- gnt0  output  1  one-cycle grant pulse to requester 0.
- gnt1  output  1  one-cycle grant pulse to requester 1.
- done0  output  1  one-cycle completion pulse to requester 0.
- done1  output  1  one-cycle completion pulse to requester 1.
- err  output  1  one-cycle pulse, coincident with done, when the address was >= NLATCH.
- lat_en  output  NLATCH  one-hot latch enables.
- lat_d  output  DW  shared latch data bus.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- All outputs are registered.
- Reset (rst_n=0 sampled at an edge):
  - state=IDLE, phase counter=0, last_gnt=1 (so req0 wins the first tie).
  - gnt0/gnt1/done0/done1/err=0, lat_en=0, lat_d=0, busy=0.
  - Reset mid-transaction aborts it: lat_en drops at that edge, no done/err is issued, and the captured request is discarded.
- States: IDLE -> SETUP -> OPEN -> HOLD -> IDLE. A down-counter loads SETUP_CYC-1, OPEN_CYC-1 or HOLD_CYC-1 on entry to each phase. A phase exits when the counter reads 0.
- Arbitration, evaluated only in IDLE:
  - Only one req high: grant it.
  - Both high: grant the requester != last_gnt.
  - On grant: update last_gnt, capture addr/wdata into internal registers, go to SETUP, pulse gntX=1 for exactly the first SETUP cycle.
- lat_d = captured data for all SETUP, OPEN and HOLD cycles. It keeps its last value in IDLE; it changes only on a new grant or reset.
- lat_en[addr]=1 for exactly OPEN_CYC cycles (the OPEN state) and is all-zero otherwise. At most one bit is ever set.
- Out-of-range address (addr >= NLATCH): the full timing sequence runs with lat_en=0 throughout, and err pulses together with done.
- Completion: on the HOLD->IDLE edge, doneX (for the granted requester) pulses for the first IDLE cycle.
- Transaction length: grant to done = SETUP_CYC+OPEN_CYC+HOLD_CYC+1 cycles.
- Back-to-back: a req sampled during the done cycle is granted at that edge. This gives exactly one IDLE cycle between transactions.
- Requester protocol: hold req, addr and wdata stable until gnt is seen; drop req in the gnt cycle. A req still high at the next IDLE sample is treated as a new request.
- Request inputs are ignored outside IDLE. Changes to addr/wdata after the grant have no effect.

Test Plan:
- Single write, defaults: req0=1, addr0=2, wdata0=0xA5 sampled at edge 0 -> cycle 1: gnt0=1, busy=1, lat_d=0xA5; cycles 2-3: lat_en=6'b000100; cycle 4: lat_en=0, lat_d=0xA5; cycle 5: done0=1, busy=0. A D latch model on bit 2 then holds q=0xA5.
- Tie: req0 and req1 asserted together from reset and held until their own grant -> requester 0 is granted first, its done arrives in cycle 5, then gnt1 follows at cycle 6. lat_d shows wdata0 and then wdata1.
- Fairness: both requesters re-request after every done for 4 transactions -> grant order is 0,1,0,1. No cycle has two lat_en bits set.
- Out-of-range: req1=1, addr1=7 -> lat_en stays 0 for the whole transaction, and done1=1 and err=1 arrive together in cycle 5.
- Reset mid-OPEN: rst_n=0 sampled in the first OPEN cycle -> next cycle lat_en=0, lat_d=0, busy=0, with no done/err. A subsequent tie is won by req0.
- Timing parameters: SETUP_CYC=2, OPEN_CYC=3, HOLD_CYC=2 -> lat_en is high for exactly 3 cycles starting 3 cycles after the gnt edge, and done arrives 8 cycles after gnt.
